// File: rtl/fifo_ctrl.sv
// Command sequencer for the 4-bit symbol FIFO: arbitrates user writes/deletes
// against a paced playback reader and keeps the authoritative occupancy count.
module fifo_ctrl #(
    parameter int DEPTH       = 32,
    parameter int PLAY_PERIOD = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    input  logic       in_del,
    input  logic       play,
    input  logic [3:0] fifo_data_out,
    output logic       fifo_we,
    output logic       fifo_re,
    output logic       fifo_del,
    output logic [3:0] fifo_data_in,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic [5:0] count,
    output logic       empty,
    output logic       full,
    output logic       ovf
);

    localparam int         TW      = $clog2(PLAY_PERIOD + 1);
    localparam logic [5:0] DEPTH_C = 6'(DEPTH);

    typedef enum logic [2:0] {IDLE, REQ, ISSUE, WAITD, CAPT, HOLD} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer;
    logic          pend_del;
    logic [6:0]    occ;
    logic          wr_acc, del_acc, del_go, rd_go;

    // The one-deep write pending slot is the registered fifo_we itself: a write
    // is issued on the edge it is accepted, so it only has to block the next one.
    // occ folds in strobes already on the bus but not yet reflected in count.
    always_comb begin
        occ     = {1'b0, count} + 7'(fifo_we) - 7'(fifo_re | fifo_del);
        wr_acc  = in_valid && !fifo_we && (count < DEPTH_C);
        del_acc = in_del && !pend_del && ((occ + 7'(wr_acc)) != 7'd0);
        del_go  = !wr_acc && (pend_del || del_acc);
        rd_go   = !wr_acc && !del_go && (state == REQ) && (occ != 7'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (play && count != 6'd0) state_nx = REQ;
            REQ: begin
                if (rd_go)              state_nx = ISSUE;
                else if (occ == 7'd0)   state_nx = IDLE;
            end
            ISSUE:   state_nx = WAITD;
            WAITD:   state_nx = CAPT;
            CAPT:    state_nx = HOLD;
            HOLD: begin
                if (timer == '0) state_nx = (play && count != 6'd0) ? REQ : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Timer is loaded as out_valid rises so CAPT plus HOLD spans PLAY_PERIOD+1 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_we      <= 1'b0;
            fifo_re      <= 1'b0;
            fifo_del     <= 1'b0;
            fifo_data_in <= 4'd0;
            pend_del     <= 1'b0;
            ovf          <= 1'b0;
            count        <= 6'd0;
            out_valid    <= 1'b0;
            out_data     <= 4'd0;
            timer        <= '0;
        end else begin
            fifo_we  <= wr_acc;
            fifo_del <= del_go;
            fifo_re  <= rd_go;
            if (wr_acc) fifo_data_in <= in_data;
            pend_del <= wr_acc && (pend_del || del_acc);
            if (in_valid && !wr_acc) ovf <= 1'b1;
            count     <= 6'(occ);
            out_valid <= (state == WAITD);
            if (state == WAITD) out_data <= fifo_data_out;
            if (state == WAITD)   timer <= TW'(PLAY_PERIOD);
            else if (timer != '0) timer <= timer - TW'(1);
        end
    end

    assign empty = (count == 6'd0);
    assign full  = (count == DEPTH_C);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with a behavioural 32-entry FIFO and scoreboard queues
// for written symbols and played-back symbols.
module tb_fifo_ctrl;

    localparam int DEPTH = 32;
    localparam int PP    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       in_del = 1'b0;
    logic       play = 1'b0;
    logic [3:0] fifo_data_out;
    logic       fifo_we, fifo_re, fifo_del;
    logic [3:0] fifo_data_in;
    logic       out_valid;
    logic [3:0] out_data;
    logic [5:0] count;
    logic       empty, full, ovf;

    fifo_ctrl #(.DEPTH(DEPTH), .PLAY_PERIOD(PP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_del(in_del), .play(play), .fifo_data_out(fifo_data_out),
        .fifo_we(fifo_we), .fifo_re(fifo_re), .fifo_del(fifo_del),
        .fifo_data_in(fifo_data_in), .out_valid(out_valid), .out_data(out_data),
        .count(count), .empty(empty), .full(full), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered read data, delete drops the newest entry.
    logic [3:0] mem [32];
    logic [4:0] wp, rp;
    always @(posedge clk) begin
        if (rst) begin
            wp <= 5'd0;
            rp <= 5'd0;
            fifo_data_out <= 4'd0;
        end else begin
            if (fifo_we) begin
                mem[wp] <= fifo_data_in;
                wp <= wp + 5'd1;
            end
            if (fifo_del) wp <= wp - 5'd1;
            if (fifo_re) begin
                fifo_data_out <= mem[rp];
                rp <= rp + 5'd1;
            end
        end
    end

    logic [3:0] exp_wr[$];
    logic [3:0] exp_play[$];
    int checks = 0, errors = 0, cyc = 0;
    int we_cnt = 0, re_cnt = 0, del_cnt = 0, ov_cnt = 0;
    int ov_cyc[2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            if (fifo_we | fifo_re | fifo_del)
                check("strobe_onehot", $countones({fifo_we, fifo_re, fifo_del}), 1);
            if (fifo_we) begin
                we_cnt++;
                check("we_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) check("we_data", fifo_data_in, exp_wr.pop_front());
            end
            if (fifo_re) re_cnt++;
            if (fifo_del) del_cnt++;
            if (out_valid) begin
                if (ov_cnt < 2) ov_cyc[ov_cnt] = cyc;
                ov_cnt++;
                check("ov_expected", exp_play.size() != 0, 1);
                if (exp_play.size() != 0) check("out_data", out_data, exp_play.pop_front());
            end
        end
    endtask

    initial begin
        logic [3:0] vals [3];
        int p;
        vals = '{4'h3, 4'h5, 4'hA};

        // Reset state
        repeat (3) tick();
        check("rst_we", fifo_we, 0);
        check("rst_re", fifo_re, 0);
        check("rst_del", fifo_del, 0);
        check("rst_ov", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();

        // Three spaced writes
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            exp_wr.push_back(vals[i]);
            tick();
            in_valid = 1'b0;
            check("we_latency", fifo_we, 1);
            tick();
        end
        check("count_3", count, 3);
        check("empty_0", empty, 0);

        // Same-cycle write and delete cancel
        in_valid = 1'b1;
        in_data  = 4'h7;
        in_del   = 1'b1;
        exp_wr.push_back(4'h7);
        tick();
        in_valid = 1'b0;
        in_del   = 1'b0;
        check("wd_we_t1", fifo_we, 1);
        check("wd_del_t1", fifo_del, 0);
        tick();
        check("wd_del_t2", fifo_del, 1);
        check("wd_we_t2", fifo_we, 0);
        tick();
        check("wd_count", count, 3);

        // Reset with a write in flight
        in_valid = 1'b1;
        in_data  = 4'h9;
        exp_wr.push_back(4'h9);
        tick();
        in_valid = 1'b0;
        rst    = 1'b1;
        in_del = 1'b1;
        tick();
        rst    = 1'b0;
        in_del = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_strobes", {fifo_we, fifo_re, fifo_del, out_valid}, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("quiet_after_rst", {fifo_we, fifo_re, fifo_del, out_valid}, 0);
        end

        // Delete while empty
        del_cnt = 0;
        in_del = 1'b1;
        tick();
        in_del = 1'b0;
        tick();
        tick();
        check("del_empty_cnt", del_cnt, 0);
        check("del_empty_count", count, 0);
        check("del_empty_ovf", ovf, 0);

        // Overflow: 33 writes
        we_cnt = 0;
        for (int i = 0; i < 33; i++) begin
            if (i == 32) begin
                check("full_before_33", full, 1);
                check("ovf_before_33", ovf, 0);
            end
            in_valid = 1'b1;
            in_data  = 4'(i);
            if (i < 32) exp_wr.push_back(4'(i));
            tick();
            in_valid = 1'b0;
            tick();
        end
        check("ovf_we_cnt", we_cnt, 32);
        check("ovf_full", full, 1);
        check("ovf_count", count, 32);
        check("ovf_set", ovf, 1);
        repeat (3) tick();
        check("ovf_sticky", ovf, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ovf_cleared", ovf, 0);
        check("full_cleared", full, 0);

        // Playback of 0x1, 0x2
        for (int i = 1; i <= 2; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            exp_wr.push_back(4'(i));
            exp_play.push_back(4'(i));
            tick();
            in_valid = 1'b0;
            tick();
        end
        tick();
        check("play_count_2", count, 2);
        re_cnt = 0;
        ov_cnt = 0;
        play = 1'b1;
        p = cyc;
        for (int k = 0; k < 60 && ov_cnt < 2; k++) tick();
        check("play_pulses", ov_cnt, 2);
        if (ov_cnt >= 2) begin
            check("first_latency", ov_cyc[0] - p, 4);
            check("pulse_spacing", ov_cyc[1] - ov_cyc[0], PP + 4);
        end
        repeat (10) tick();
        check("play_reads", re_cnt, 2);
        check("play_end_count", count, 0);
        check("play_end_empty", empty, 1);
        check("play_held_data", out_data, 4'h2);
        check("play_queue_drained", exp_play.size(), 0);
        check("wr_queue_drained", exp_wr.size(), 0);
        play = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
